// File: rtl/ram_bus_arbiter_if.sv
// Requester and RAM-control signals of ram_bus_arbiter, bundled with arbiter/environment views.
// fault0/fault1 exist only when RAM_ARB_ALIGN_CHECK_EN is defined.
interface ram_bus_arbiter_if;
    logic        req0;
    logic        we0;
    logic [31:0] addr0;
    logic [1:0]  size0;
    logic [63:0] wdata0;
    logic        ack0;
    logic [63:0] rdata0;

    logic        req1;
    logic        we1;
    logic [31:0] addr1;
    logic [1:0]  size1;
    logic [63:0] wdata1;
    logic        ack1;
    logic [63:0] rdata1;

    logic [31:0] mem_address;
    logic [1:0]  mem_size;
    logic        mem_read;
    logic        mem_write;
    logic        busy;

`ifdef RAM_ARB_ALIGN_CHECK_EN
    logic        fault0;
    logic        fault1;
`endif

    // Arbiter side.
    modport slave (
`ifdef RAM_ARB_ALIGN_CHECK_EN
        output fault0, fault1,
`endif
        input  req0, we0, addr0, size0, wdata0,
        input  req1, we1, addr1, size1, wdata1,
        output ack0, rdata0, ack1, rdata1,
        output mem_address, mem_size, mem_read, mem_write, busy
    );

    // Requesters and RAM side.
    modport master (
`ifdef RAM_ARB_ALIGN_CHECK_EN
        input  fault0, fault1,
`endif
        output req0, we0, addr0, size0, wdata0,
        output req1, we1, addr1, size1, wdata1,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_address, mem_size, mem_read, mem_write, busy
    );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Round-robin two-port arbiter/sequencer for the shared 64-bit RAM bus; owns the mem_data driver.
// Optional alignment checking is enabled by defining RAM_ARB_ALIGN_CHECK_EN.
module ram_bus_arbiter #(
    parameter int unsigned READ_WAIT    = 1,
    parameter int unsigned WRITE_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    ram_bus_arbiter_if.slave  bus,
    // Kept as a plain inout so the tristate resolves at the module boundary.
    inout  wire  [63:0]       mem_data
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    localparam logic [2:0] ReadLast  = 3'(READ_WAIT);
    localparam logic [2:0] WriteLast = 3'(WRITE_CYCLES - 1);

    state_e      state_q;
    logic        last_grant_q;
    logic        port_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [63:0] wdata_q;
    logic [2:0]  cnt_q;
    logic [63:0] rdata0_q;
    logic [63:0] rdata1_q;
    logic        ack0_q;
    logic        ack1_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic        busy_q;

    logic        grant_valid;
    logic        grant_port;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [1:0]  sel_size;
    logic [63:0] sel_wdata;

    function automatic logic [63:0] size_mask(input logic [1:0] size, input logic [63:0] data);
        logic [63:0] masked;
        case (size)
            2'b00:   masked = {56'd0, data[7:0]};
            2'b01:   masked = {48'd0, data[15:0]};
            2'b10:   masked = {32'd0, data[31:0]};
            default: masked = data;
        endcase
        return masked;
    endfunction

`ifdef RAM_ARB_ALIGN_CHECK_EN
    logic fault0_q;
    logic fault1_q;
    logic sel_misaligned;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lsb);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lsb[0];
            2'b10:   bad = |lsb[1:0];
            default: bad = |lsb;
        endcase
        return bad;
    endfunction

    assign sel_misaligned = is_misaligned(sel_size, sel_addr[2:0]);
    assign bus.fault0     = fault0_q;
    assign bus.fault1     = fault1_q;
`endif

    // With both ports requesting, the one not granted last time wins.
    always_comb begin
        grant_valid = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            grant_port = ~last_grant_q;
        end else begin
            grant_port = bus.req1;
        end
        if (grant_port) begin
            sel_we    = bus.we1;
            sel_addr  = bus.addr1;
            sel_size  = bus.size1;
            sel_wdata = bus.wdata1;
        end else begin
            sel_we    = bus.we0;
            sel_addr  = bus.addr0;
            sel_size  = bus.size0;
            sel_wdata = bus.wdata0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef RAM_ARB_ALIGN_CHECK_EN
            fault0_q     <= 1'b0;
            fault1_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        port_q       <= grant_port;
                        last_grant_q <= grant_port;
                        addr_q       <= sel_addr;
                        size_q       <= sel_size;
                        wdata_q      <= sel_wdata;
                        cnt_q        <= '0;
                        busy_q       <= 1'b1;
`ifdef RAM_ARB_ALIGN_CHECK_EN
                        if (sel_misaligned) begin
                            state_q  <= StDone;
                            ack0_q   <= ~grant_port;
                            ack1_q   <= grant_port;
                            fault0_q <= ~grant_port;
                            fault1_q <= grant_port;
                        end else
`endif
                        if (sel_we) begin
                            state_q     <= StWrite;
                            mem_write_q <= 1'b1;
                        end else begin
                            state_q    <= StRead;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    if (cnt_q == ReadLast) begin
                        if (port_q) begin
                            rdata1_q <= size_mask(size_q, mem_data);
                        end else begin
                            rdata0_q <= size_mask(size_q, mem_data);
                        end
                        mem_read_q <= 1'b0;
                        ack0_q     <= ~port_q;
                        ack1_q     <= port_q;
                        state_q    <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                StWrite: begin
                    if (cnt_q == WriteLast) begin
                        mem_write_q <= 1'b0;
                        ack0_q      <= ~port_q;
                        ack1_q      <= port_q;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                StDone: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
`ifdef RAM_ARB_ALIGN_CHECK_EN
                    fault0_q <= 1'b0;
                    fault1_q <= 1'b0;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // mem_write_q is high exactly in WRITE, so it doubles as the data-driver enable.
    assign mem_data        = mem_write_q ? wdata_q : {64{1'bz}};
    assign bus.mem_address = addr_q;
    assign bus.mem_size    = size_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.busy        = busy_q;
    assign bus.ack0        = ack0_q;
    assign bus.ack1        = ack1_q;
    assign bus.rdata0      = rdata0_q;
    assign bus.rdata1      = rdata1_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter: default instance plus a READ_WAIT=3/WRITE_CYCLES=2 instance.
// Fault checks run only when RAM_ARB_ALIGN_CHECK_EN is defined.
module tb_ram_bus_arbiter;

    logic clock     = 1'b0;
    logic reset     = 1'b0;
    logic ram_clear = 1'b1;
    // Pulled up so an undriven bus reads as all ones.
    tri1 [63:0] mem_data;
    tri1 [63:0] mem_data_s;
    logic [63:0] ram [0:7];
    int   checks = 0;
    int   errors = 0;
    logic ack_overlap  = 1'b0;
    logic strobe_clash = 1'b0;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [63:0] wdata;
        int          lat;
        logic [63:0] rd0;
        logic [63:0] rd1;
    } vec_t;

    ram_bus_arbiter_if bus ();
    ram_bus_arbiter_if bus_s ();

    ram_bus_arbiter dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .mem_data (mem_data)
    );

    ram_bus_arbiter #(
        .READ_WAIT    (3),
        .WRITE_CYCLES (2)
    ) dut_slow (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus_s),
        .mem_data (mem_data_s)
    );

    always #5 clock = ~clock;

    assign mem_data   = bus.mem_read ? ram[bus.mem_address[5:3]] : {64{1'bz}};
    assign mem_data_s = bus_s.mem_read ? 64'h0123_4567_89AB_CDEF : {64{1'bz}};

    always @(posedge clock) begin
        if (ram_clear) begin
            for (int i = 0; i < 8; i++) ram[i] <= '0;
            ram[1] <= 64'hFFFF_FFFF_FFFF_FFAB;
        end else if (bus.mem_write) begin
            ram[bus.mem_address[5:3]] <= mem_data;
        end
    end

    always @(negedge clock) begin
        if (bus.ack0 && bus.ack1) ack_overlap <= 1'b1;
        if ((bus.mem_read && bus.mem_write) || (bus_s.mem_read && bus_s.mem_write))
            strobe_clash <= 1'b1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive_port(input logic port, input logic req, input logic we,
                              input logic [31:0] addr, input logic [1:0] size,
                              input logic [63:0] wdata);
        if (port) begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.size1 = size; bus.wdata1 = wdata;
        end else begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.size0 = size; bus.wdata0 = wdata;
        end
    endtask

    // Issues one request, scrambles the port inputs once granted, returns when the DUT is idle.
    task automatic run_txn(input logic port, input logic we, input logic [31:0] addr,
                           input logic [1:0] size, input logic [63:0] wdata,
                           output int lat, output int rd_cyc, output int wr_cyc,
                           output logic [63:0] wr_seen, output logic flt, output logic stray);
        lat = 0; rd_cyc = 0; wr_cyc = 0; wr_seen = '0; flt = 1'b0; stray = 1'b0;
        drive_port(port, 1'b1, we, addr, size, wdata);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (n == 1) drive_port(port, 1'b1, ~we, ~addr, ~size, ~wdata);
            if (bus.mem_read) rd_cyc++;
            if (bus.mem_write) begin
                wr_cyc++;
                wr_seen = mem_data;
            end
            if (port ? bus.ack0 : bus.ack1) stray = 1'b1;
            if (port ? bus.ack1 : bus.ack0) begin
                lat = n;
`ifdef RAM_ARB_ALIGN_CHECK_EN
                flt = port ? bus.fault1 : bus.fault0;
`endif
                break;
            end
        end
        drive_port(port, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clock);
    endtask

    initial begin
        vec_t        vecs [9];
        int          lat, rd_cyc, wr_cyc;
        logic [63:0] wr_seen;
        logic        flt, stray, gap_pending;
        int          ack_order [$];
        int          got_port;

        vecs[0] = '{1'b1, 1'b1, 32'h10, 2'b11, 64'h1122_3344_5566_7788, 2, 64'h0, 64'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h10, 2'b11, 64'h0, 3, 64'h0, 64'h1122_3344_5566_7788};
        vecs[2] = '{1'b0, 1'b0, 32'h08, 2'b00, 64'h0, 3, 64'hAB, 64'h1122_3344_5566_7788};
        vecs[3] = '{1'b0, 1'b0, 32'h08, 2'b01, 64'h0, 3, 64'hFFAB, 64'h1122_3344_5566_7788};
        vecs[4] = '{1'b0, 1'b0, 32'h08, 2'b10, 64'h0, 3, 64'hFFFF_FFAB, 64'h1122_3344_5566_7788};
        vecs[5] = '{1'b0, 1'b1, 32'h20, 2'b00, 64'hDEAD_BEEF_CAFE_F00D, 2, 64'hFFFF_FFAB,
                    64'h1122_3344_5566_7788};
        vecs[6] = '{1'b1, 1'b0, 32'h20, 2'b00, 64'h0, 3, 64'hFFFF_FFAB, 64'h0D};
        vecs[7] = '{1'b0, 1'b0, 32'h20, 2'b01, 64'h0, 3, 64'hF00D, 64'h0D};
        vecs[8] = '{1'b1, 1'b0, 32'h20, 2'b10, 64'h0, 3, 64'hF00D, 64'hCAFE_F00D};

        drive_port(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive_port(1'b1, 1'b0, 1'b0, '0, '0, '0);
        bus_s.req0 = 1'b0; bus_s.we0 = 1'b0; bus_s.addr0 = '0; bus_s.size0 = '0; bus_s.wdata0 = '0;
        bus_s.req1 = 1'b0; bus_s.we1 = 1'b0; bus_s.addr1 = '0; bus_s.size1 = '0; bus_s.wdata1 = '0;

        repeat (3) @(negedge clock);
        check("rst_ack0", 64'(bus.ack0), 64'd0);
        check("rst_ack1", 64'(bus.ack1), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_mem_read", 64'(bus.mem_read), 64'd0);
        check("rst_mem_write", 64'(bus.mem_write), 64'd0);
        check("rst_mem_address", 64'(bus.mem_address), 64'd0);
        check("rst_rdata0", bus.rdata0, 64'd0);
        check("rst_rdata1", bus.rdata1, 64'd0);
        check("rst_mem_data_z", mem_data, {64{1'b1}});
        reset = 1'b1;
        ram_clear = 1'b0;
        @(negedge clock);

        foreach (vecs[i]) begin
            run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata,
                    lat, rd_cyc, wr_cyc, wr_seen, flt, stray);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_read_cycles", i), 64'(rd_cyc), vecs[i].we ? 64'd0 : 64'd2);
            check($sformatf("v%0d_write_cycles", i), 64'(wr_cyc), vecs[i].we ? 64'd1 : 64'd0);
            if (vecs[i].we) begin
                check($sformatf("v%0d_bus_wdata", i), wr_seen, vecs[i].wdata);
                check($sformatf("v%0d_ram", i), ram[vecs[i].addr[5:3]], vecs[i].wdata);
            end
            check($sformatf("v%0d_rdata0", i), bus.rdata0, vecs[i].rd0);
            check($sformatf("v%0d_rdata1", i), bus.rdata1, vecs[i].rd1);
            check($sformatf("v%0d_other_ack", i), 64'(stray), 64'd0);
`ifdef RAM_ARB_ALIGN_CHECK_EN
            check($sformatf("v%0d_fault", i), 64'(flt), 64'd0);
`endif
        end

        // Reset held low for three cycles in the middle of a read.
        drive_port(1'b0, 1'b1, 1'b0, 32'h08, 2'b11, '0);
        @(negedge clock);
        check("midrst_read_started", 64'(bus.mem_read), 64'd1);
        reset = 1'b0;
        drive_port(1'b0, 1'b0, 1'b0, '0, '0, '0);
        for (int n = 1; n <= 3; n++) begin
            @(negedge clock);
            check($sformatf("midrst%0d_ack0", n), 64'(bus.ack0), 64'd0);
            check($sformatf("midrst%0d_mem_read", n), 64'(bus.mem_read), 64'd0);
            check($sformatf("midrst%0d_busy", n), 64'(bus.busy), 64'd0);
            check($sformatf("midrst%0d_mem_data_z", n), mem_data, {64{1'b1}});
        end
        reset = 1'b1;
        check("midrst_rdata0", bus.rdata0, 64'd0);
        check("midrst_rdata1", bus.rdata1, 64'd0);
        repeat (2) @(negedge clock);
        check("postrst_busy", 64'(bus.busy), 64'd0);
        check("postrst_ack0", 64'(bus.ack0), 64'd0);

        // Both ports requesting back to back from reset: port 0 first, then strict alternation.
        drive_port(1'b0, 1'b1, 1'b0, 32'h08, 2'b00, '0);
        drive_port(1'b1, 1'b1, 1'b0, 32'h10, 2'b11, '0);
        gap_pending = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clock);
            if (gap_pending) begin
                check($sformatf("fair_idle_gap_%0d", n), 64'(bus.busy), 64'd0);
                gap_pending = 1'b0;
            end
            if (bus.ack0) begin ack_order.push_back(0); gap_pending = 1'b1; end
            if (bus.ack1) begin ack_order.push_back(1); gap_pending = 1'b1; end
        end
        drive_port(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive_port(1'b1, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clock);
        check("fair_ack_count", 64'(ack_order.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            got_port = (k < ack_order.size()) ? ack_order[k] : 99;
            check($sformatf("fair_order_%0d", k), 64'(got_port), 64'(k % 2));
        end
        check("fair_rdata0", bus.rdata0, 64'hAB);
        check("fair_rdata1", bus.rdata1, 64'h1122_3344_5566_7788);

        // Slow instance: READ_WAIT=3, WRITE_CYCLES=2.
        bus_s.req0 = 1'b1; bus_s.we0 = 1'b0; bus_s.addr0 = 32'h0; bus_s.size0 = 2'b11;
        lat = 0; rd_cyc = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (bus_s.mem_read) rd_cyc++;
            if (bus_s.ack0) begin lat = n; break; end
        end
        bus_s.req0 = 1'b0;
        check("slow_read_latency", 64'(lat), 64'd5);
        check("slow_read_cycles", 64'(rd_cyc), 64'd4);
        check("slow_rdata0", bus_s.rdata0, 64'h0123_4567_89AB_CDEF);
        @(negedge clock);
        check("slow_idle_busy", 64'(bus_s.busy), 64'd0);
        bus_s.req1 = 1'b1; bus_s.we1 = 1'b1; bus_s.addr1 = 32'h40; bus_s.size1 = 2'b11;
        bus_s.wdata1 = 64'h5A5A_0F0F_1234_8765;
        lat = 0; wr_cyc = 0; wr_seen = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (bus_s.mem_write) begin wr_cyc++; wr_seen = mem_data_s; end
            if (bus_s.ack1) begin lat = n; break; end
        end
        bus_s.req1 = 1'b0;
        check("slow_write_latency", 64'(lat), 64'd3);
        check("slow_write_cycles", 64'(wr_cyc), 64'd2);
        check("slow_bus_wdata", wr_seen, 64'h5A5A_0F0F_1234_8765);
        check("slow_rdata1", bus_s.rdata1, 64'd0);
        @(negedge clock);

`ifdef RAM_ARB_ALIGN_CHECK_EN
        run_txn(1'b1, 1'b0, 32'h13, 2'b10, '0, lat, rd_cyc, wr_cyc, wr_seen, flt, stray);
        check("mis32_latency", 64'(lat), 64'd1);
        check("mis32_fault1", 64'(flt), 64'd1);
        check("mis32_read_cycles", 64'(rd_cyc), 64'd0);
        check("mis32_rdata1", bus.rdata1, 64'h1122_3344_5566_7788);
        run_txn(1'b0, 1'b1, 32'h0C, 2'b11, 64'h1, lat, rd_cyc, wr_cyc, wr_seen, flt, stray);
        check("mis64_latency", 64'(lat), 64'd1);
        check("mis64_fault0", 64'(flt), 64'd1);
        check("mis64_write_cycles", 64'(wr_cyc), 64'd0);
        check("mis64_ram", ram[1], 64'hFFFF_FFFF_FFFF_FFAB);
        run_txn(1'b1, 1'b0, 32'h12, 2'b01, '0, lat, rd_cyc, wr_cyc, wr_seen, flt, stray);
        check("al16_latency", 64'(lat), 64'd3);
        check("al16_fault1", 64'(flt), 64'd0);
        check("al16_rdata1", bus.rdata1, 64'h7788);
`endif

        check("ack_overlap", 64'(ack_overlap), 64'd0);
        check("strobe_clash", 64'(strobe_clash), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
